// File: rtl/pixel_sink_pkg.sv
// Shared screen geometry, pixel payload and state encoding for the pixel sink.
package pixel_sink_pkg;

   localparam int unsigned WIDTH        = 160;
   localparam int unsigned HEIGHT       = 120;
   localparam int unsigned COLOUR_BITS  = 3;
   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned ADDR_BITS    = 15;
   localparam int unsigned CLEAR_COLOUR = 0;
   localparam int unsigned COORD_BITS   = 10;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   typedef struct packed {
      logic [COORD_BITS-1:0]  x;
      logic [COORD_BITS-1:0]  y;
      logic [COLOUR_BITS-1:0] colour;
   } pixel_t;

   // Row-major frame-buffer address; operands are in range so no truncation occurs.
   function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [COORD_BITS-1:0] px,
                                                       input logic [COORD_BITS-1:0] py);
      return ADDR_BITS'(py) * ADDR_BITS'(WIDTH) + ADDR_BITS'(px);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO buffering accepted pixels ahead of the memory write stage.
module pixel_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_c,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign head_c = mem[rd_ptr];

endmodule

// File: rtl/pixel_sink.sv
// Pixel-write receiver: range check, buffering, frame-buffer address generation
// and a full-screen clear sweep, all behind a registered memory write port.
module pixel_sink
   import pixel_sink_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [COORD_BITS-1:0]  x,
   input  logic [COORD_BITS-1:0]  y,
   input  logic [COLOUR_BITS-1:0] colour,
   input  logic                   writeEn,
   input  logic                   clear,
   output logic                   ready,
   output logic [ADDR_BITS-1:0]   mem_addr,
   output logic [COLOUR_BITS-1:0] mem_data,
   output logic                   mem_we,
   input  logic                   mem_ready,
   output logic                   clearing,
   output logic                   oob
);

   localparam int unsigned PIXELS  = WIDTH * HEIGHT;
   localparam int unsigned SWEEP_W = ADDR_BITS + 1;
   localparam int unsigned PIX_W   = $bits(pixel_t);

   state_t                 state, state_nxt;
   logic                   clear_pending, pend_nxt;
   logic [SWEEP_W-1:0]     sweep_cnt, sweep_nxt;
   logic [ADDR_BITS-1:0]   addr_nxt;
   logic [COLOUR_BITS-1:0] data_nxt;
   logic                   we_nxt;
   logic                   oob_nxt;
   logic                   pop;
   logic                   push;
   logic                   accept;
   logic                   in_range;
   logic                   stage_free;
   logic                   fifo_full;
   logic                   fifo_empty;
   pixel_t                 wr_pix;
   pixel_t                 head;

   assign ready      = (state == S_RUN) && !clear_pending && !fifo_full;
   assign accept     = writeEn && ready;
   assign in_range   = (x < COORD_BITS'(WIDTH)) && (y < COORD_BITS'(HEIGHT));
   assign push       = accept && in_range;
   assign stage_free = !mem_we || mem_ready;
   assign wr_pix     = '{x: x, y: y, colour: colour};

   pixel_fifo #(
      .DATA_W (PIX_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (push),
      .wr_data (wr_pix),
      .pop     (pop),
      .head_c  (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Next-state, pop control and next values of the registered memory port.
   always_comb begin
      state_nxt = state;
      pend_nxt  = clear_pending;
      sweep_nxt = sweep_cnt;
      addr_nxt  = mem_addr;
      data_nxt  = mem_data;
      we_nxt    = mem_we;
      pop       = 1'b0;
      oob_nxt   = accept && !in_range;

      unique case (state)
         S_RUN, S_DRAIN: begin
            if (stage_free) begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  addr_nxt = pixel_addr(head.x, head.y);
                  data_nxt = head.colour;
                  we_nxt   = 1'b1;
               end else begin
                  we_nxt = 1'b0;
               end
            end
            if (state == S_RUN) begin
               if (clear) begin
                  pend_nxt  = 1'b1;
                  state_nxt = S_DRAIN;
               end
            end else if (fifo_empty && stage_free) begin
               state_nxt = S_CLEAR;
               sweep_nxt = '0;
               pend_nxt  = 1'b0;
            end
         end
         S_CLEAR: begin
            // sweep_cnt counts issued writes; reaching PIXELS with a free stage means the last one landed.
            if (stage_free) begin
               if (sweep_cnt == SWEEP_W'(PIXELS)) begin
                  state_nxt = S_RUN;
                  we_nxt    = 1'b0;
               end else begin
                  addr_nxt  = ADDR_BITS'(sweep_cnt);
                  data_nxt  = COLOUR_BITS'(CLEAR_COLOUR);
                  we_nxt    = 1'b1;
                  sweep_nxt = sweep_cnt + SWEEP_W'(1);
               end
            end
         end
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_RUN;
         clear_pending <= 1'b0;
         sweep_cnt     <= '0;
         mem_addr      <= '0;
         mem_data      <= '0;
         mem_we        <= 1'b0;
         clearing      <= 1'b0;
         oob           <= 1'b0;
      end else begin
         state         <= state_nxt;
         clear_pending <= pend_nxt;
         sweep_cnt     <= sweep_nxt;
         mem_addr      <= addr_nxt;
         mem_data      <= data_nxt;
         mem_we        <= we_nxt;
         clearing      <= (state_nxt == S_CLEAR);
         oob           <= oob_nxt;
      end
   end

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: directed table, corner sequences and a
// randomized run against an ordered expected-write queue model.
`timescale 1ns/1ps
module tb_pixel_sink;

   localparam int W   = 160;
   localparam int H   = 120;
   localparam int CLR = 0;

   logic        clk = 1'b0;
   logic        resetn;
   logic [9:0]  x, y;
   logic [2:0]  colour;
   logic        writeEn, clear;
   logic        ready;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_we, mem_ready;
   logic        clearing, oob;

   pixel_sink dut (
      .clk       (clk),
      .resetn    (resetn),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .writeEn   (writeEn),
      .clear     (clear),
      .ready     (ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .clearing  (clearing),
      .oob       (oob)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; bit sweep; } wr_t;
   typedef struct { int x; int y; int c; bit oob; int addr; } vec_t;

   wr_t exp_q[$];
   bit  busy, oob_due, stalled;
   int  held_addr, held_data;
   int  sweep_writes;
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      busy    = 1'b0;
      oob_due = 1'b0;
      stalled = 1'b0;
   endtask

   // One clock: drive at the falling edge, check, update the model, advance.
   task automatic cyc(input bit we, input int px, input int py, input int pc,
                      input bit clr, input bit mrdy);
      wr_t e;
      writeEn = we; x = 10'(px); y = 10'(py); colour = 3'(pc);
      clear = clr; mem_ready = mrdy;
      #1;
      chk("oob_pulse", int'(oob), int'(oob_due));
      if (stalled) begin
         chk("hold_we", int'(mem_we), 1);
         chk("hold_addr", int'(mem_addr), held_addr);
         chk("hold_data", int'(mem_data), held_data);
      end
      if (busy) chk("ready_while_clear", int'(ready), 0);
      oob_due = 1'b0;
      if (writeEn && ready) begin
         if (px < W && py < H) begin
            e = '{addr: py * W + px, data: pc, sweep: 1'b0};
            exp_q.push_back(e);
         end else begin
            oob_due = 1'b1;
         end
      end
      if (clear && !busy) begin
         busy = 1'b1;
         for (int a = 0; a < W * H; a++) begin
            e = '{addr: a, data: CLR, sweep: 1'b1};
            exp_q.push_back(e);
         end
      end
      if (mem_we && mem_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: got addr %0d data %0d expected no write at %0t",
                     mem_addr, mem_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", int'(mem_addr), e.addr);
            chk("wr_data", int'(mem_data), e.data);
            chk("wr_clearing", int'(clearing), int'(e.sweep));
            if (e.sweep) sweep_writes++;
            if (e.sweep && e.addr == W * H - 1) busy = 1'b0;
         end
      end
      stalled   = mem_we && !mem_ready;
      held_addr = int'(mem_addr);
      held_data = int'(mem_data);
      @(negedge clk);
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mem_we) && n < max_cyc) begin
         cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || mem_we) begin
         errors++;
         $display("FAIL drain_timeout: got %0d writes outstanding expected 0 after %0d cycles",
                  exp_q.size(), n);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_addr"}, int'(mem_addr), 0);
      chk({tag, "_data"}, int'(mem_data), 0);
      chk({tag, "_we"}, int'(mem_we), 0);
      chk({tag, "_clearing"}, int'(clearing), 0);
      chk({tag, "_oob"}, int'(oob), 0);
      chk({tag, "_ready"}, int'(ready), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      int   n;
      tbl[0] = '{x: 3,    y: 2,    c: 5, oob: 1'b0, addr: 323};
      tbl[1] = '{x: 0,    y: 0,    c: 7, oob: 1'b0, addr: 0};
      tbl[2] = '{x: 159,  y: 119,  c: 1, oob: 1'b0, addr: 19199};
      tbl[3] = '{x: 160,  y: 0,    c: 2, oob: 1'b1, addr: 0};
      tbl[4] = '{x: 0,    y: 120,  c: 3, oob: 1'b1, addr: 0};
      tbl[5] = '{x: 1,    y: 1,    c: 6, oob: 1'b0, addr: 161};
      tbl[6] = '{x: 1023, y: 1023, c: 4, oob: 1'b1, addr: 0};
      tbl[7] = '{x: 159,  y: 0,    c: 2, oob: 1'b0, addr: 159};
      tbl[8] = '{x: 0,    y: 119,  c: 1, oob: 1'b0, addr: 19040};

      resetn = 1'b0; writeEn = 1'b0; clear = 1'b0; mem_ready = 1'b1;
      x = '0; y = '0; colour = '0;
      sweep_writes = 0;
      model_reset();
      #12;
      check_idle_outputs("reset");
      @(negedge clk);
      resetn = 1'b1;

      // Single writes: oob one cycle after accept, memory write one cycle later.
      foreach (tbl[i]) begin
         cyc(1'b1, tbl[i].x, tbl[i].y, tbl[i].c, 1'b0, 1'b1);
         chk("tbl_oob", int'(oob), int'(tbl[i].oob));
         chk("tbl_we_early", int'(mem_we), 0);
         cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
         chk("tbl_we", int'(mem_we), int'(!tbl[i].oob));
         if (!tbl[i].oob) begin
            chk("tbl_addr", int'(mem_addr), tbl[i].addr);
            chk("tbl_data", int'(mem_data), tbl[i].c);
         end
         cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
         chk("tbl_we_off", int'(mem_we), 0);
         chk("tbl_oob_off", int'(oob), 0);
      end

      // Back-pressure: one pixel in the output stage, four in the FIFO.
      for (int i = 0; i < 5; i++) begin
         chk("fill_ready", int'(ready), 1);
         cyc(1'b1, 10 + i, 0, i + 1, 1'b0, 1'b0);
      end
      chk("full_ready", int'(ready), 0);
      chk("stall_addr", int'(mem_addr), 10);
      chk("stall_we", int'(mem_we), 1);
      for (int i = 0; i < 5; i++) begin
         chk("burst_addr", int'(mem_addr), 10 + i);
         chk("burst_we", int'(mem_we), 1);
         cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
      end
      chk("burst_end_we", int'(mem_we), 0);

      // Sustained throughput of one pixel per cycle.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 20 + i, 3, 3, 1'b0, 1'b1);
         if (i > 0) chk("stream_addr", int'(mem_addr), 3 * W + 20 + i - 1);
      end
      drain(20);

      // Clear with two pixels queued and a third arriving with the clear pulse.
      cyc(1'b1, 5, 5, 3, 1'b0, 1'b0);
      cyc(1'b1, 6, 5, 2, 1'b0, 1'b0);
      cyc(1'b1, 7, 7, 4, 1'b1, 1'b1);
      chk("clear_ready_drop", int'(ready), 0);
      sweep_writes = 0;
      drain(25000);
      chk("sweep_count", sweep_writes, W * H);
      chk("post_clear_clearing", int'(clearing), 0);
      chk("post_clear_ready", int'(ready), 1);

      // Reset in the middle of a sweep.
      cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
      n = 0;
      while (!(clearing && mem_we && mem_addr == 15'd500) && n < 2000) begin
         cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
         n++;
      end
      chk("reach_500", int'(mem_addr), 500);
      resetn = 1'b0;
      #1;
      check_idle_outputs("midsweep_reset");
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      cyc(1'b1, 1, 1, 6, 1'b0, 1'b1);
      cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
      chk("after_reset_addr", int'(mem_addr), 161);
      chk("after_reset_data", int'(mem_data), 6);
      chk("after_reset_we", int'(mem_we), 1);
      drain(10);

      // A second clear during the sweep is ignored.
      sweep_writes = 0;
      cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
      repeat (300) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
      chk("in_sweep_clearing", int'(clearing), 1);
      cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
      drain(25000);
      chk("single_sweep", sweep_writes, W * H);
      repeat (5) cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
      chk("no_second_sweep", int'(mem_we), 0);

      // Randomized traffic with random back-pressure and some out-of-range pixels.
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 175)), int'($urandom_range(0, 130)),
             int'($urandom_range(0, 7)), 1'b0, ($urandom_range(0, 9) < 7));
      end
      drain(100);
      cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
      chk("final_ready", int'(ready), 1);
      chk("final_we", int'(mem_we), 0);
      chk("final_clearing", int'(clearing), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
